nibble_fifo: RTL and testbench

//   Synchronous FIFO that buffers nibbles from the upstream FtypeD 4-bit D register stage.

---
 rtl/nibble_fifo.sv | 129 ++++++++++++
 tb/tb_nibble_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/nibble_fifo.sv
// nibble_fifo: single-clock FIFO buffering nibbles from the upstream D register
// stage. Tracks occupancy, raises full/empty, and latches sticky error flags
// for writes into a full FIFO and reads from an empty one.
module nibble_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clc,
    input  logic             Res,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0]    DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             full_r;
    logic             empty_r;
    logic [WIDTH-1:0] dout_r;
    logic             dout_vld_r;
    logic             overflow_r;
    logic             underflow_r;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;

    // Request acceptance, error events and next occupancy.
    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    always_comb begin
        rd_acc_s    = 1'b0;
        wr_acc_s    = 1'b0;
        ovf_evt_s   = 1'b0;
        unf_evt_s   = 1'b0;
        count_nxt_s = count_r;
        rd_acc_s    = rd_en && (count_r != CNT_ZERO);
        wr_acc_s    = wr_en && ((count_r != DEPTH_C) || rd_acc_s);
        ovf_evt_s   = wr_en && !wr_acc_s;
        unf_evt_s   = rd_en && !rd_acc_s;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy and the full/empty decodes, kept registered alongside count.
    always_ff @(posedge clc) begin
        if (!Res) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == DEPTH_C);
            empty_r <= (count_nxt_s == CNT_ZERO);
        end
    end

    // Storage array; a write is blocked while reset is asserted.
    always_ff @(posedge clc) begin
        if (Res && wr_acc_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Registered read data with a one-cycle valid pulse; dout holds between reads.
    always_ff @(posedge clc) begin
        if (!Res) begin
            dout_r     <= DATA_ZERO;
            dout_vld_r <= 1'b0;
        end else begin
            if (rd_acc_s) begin
                dout_r <= mem_r[rd_ptr_r];
            end
            dout_vld_r <= rd_acc_s;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clc) begin
        if (!Res) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end
            if (unf_evt_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign dout      = dout_r;
    assign dout_vld  = dout_vld_r;
    assign full      = full_r;
    assign empty     = empty_r;
    assign count     = count_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_nibble_fifo.sv
// tb_nibble_fifo: directed and randomized stimulus against a queue-based model
// of the nibble FIFO, with literal expectations pinning key results.
module tb_nibble_fifo;

    logic       clc = 1'b0;
    logic       Res = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] din = 4'h0;
    logic       rd_en = 1'b0;
    logic [3:0] dout;
    logic       dout_vld;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    logic [3:0] q[$];
    logic [3:0] m_dout = 4'h0;
    logic       m_vld  = 1'b0;
    logic       m_ovf  = 1'b0;
    logic       m_unf  = 1'b0;

    nibble_fifo #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
        .clc(clc), .Res(Res), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .dout_vld(dout_vld), .full(full), .empty(empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clc = ~clc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Apply one cycle of stimulus, advance the model, then compare all outputs.
    task automatic cycle(input logic res, input logic wr, input logic [3:0] d, input logic rd);
        bit rd_ok;
        bit wr_ok;
        int sz;
        Res   = res;
        wr_en = wr;
        din   = d;
        rd_en = rd;
        @(posedge clc);
        sz = q.size();
        if (!res) begin
            q.delete();
            m_dout = 4'h0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            rd_ok = rd && (sz > 0);
            wr_ok = wr && ((sz < 4) || rd_ok);
            if (rd && !rd_ok) m_unf = 1'b1;
            if (wr && !wr_ok) m_ovf = 1'b1;
            m_vld = rd_ok;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
        end
        #1;
        chk("dout",      32'(dout),      32'(m_dout));
        chk("dout_vld",  32'(dout_vld),  32'(m_vld));
        chk("count",     32'(count),     32'(q.size()));
        chk("full",      32'(full),      32'(q.size() == 4));
        chk("empty",     32'(empty),     32'(q.size() == 0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    initial begin
        logic [3:0] fill_v [4];
        fill_v[0] = 4'hC; fill_v[1] = 4'h0; fill_v[2] = 4'hF; fill_v[3] = 4'h3;

        // 1. reset held two edges with a write request
        cycle(1'b0, 1'b1, 4'h7, 1'b0);
        cycle(1'b0, 1'b1, 4'h7, 1'b0);
        chk("lit_rst_count", 32'(count), 32'd0);
        chk("lit_rst_empty", 32'(empty), 32'd1);
        chk("lit_rst_dout",  32'(dout),  32'd0);

        // 2. fill then drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, fill_v[i], 1'b0);
        chk("lit_fill_full",  32'(full),  32'd1);
        chk("lit_fill_count", 32'(count), 32'd4);

        // 3. overflow from full
        cycle(1'b1, 1'b1, 4'hA, 1'b0);
        chk("lit_ovf",       32'(overflow), 32'd1);
        chk("lit_ovf_count", 32'(count),    32'd4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 4'h0, 1'b1);
            chk("lit_drain_dout", 32'(dout),     32'(fill_v[i]));
            chk("lit_drain_vld",  32'(dout_vld), 32'd1);
        end
        chk("lit_drain_empty", 32'(empty), 32'd1);

        // 4. underflow from empty
        cycle(1'b1, 1'b0, 4'h0, 1'b1);
        chk("lit_unf",      32'(underflow), 32'd1);
        chk("lit_unf_vld",  32'(dout_vld),  32'd0);
        chk("lit_unf_dout", 32'(dout),      32'h3);

        // 5. simultaneous requests when full and when empty
        cycle(1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b1, 4'(i), 1'b0);
        cycle(1'b1, 1'b1, 4'h5, 1'b1);
        chk("lit_sim_full_dout",  32'(dout),     32'h1);
        chk("lit_sim_full_count", 32'(count),    32'd4);
        chk("lit_sim_full_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 4'h0, 1'b1);
        chk("lit_sim_last", 32'(dout), 32'h5);
        cycle(1'b1, 1'b1, 4'h9, 1'b1);
        chk("lit_sim_empty_count", 32'(count),     32'd1);
        chk("lit_sim_empty_unf",   32'(underflow), 32'd1);
        chk("lit_sim_empty_vld",   32'(dout_vld),  32'd0);
        cycle(1'b1, 1'b0, 4'h0, 1'b1);
        chk("lit_sim_empty_read", 32'(dout), 32'h9);

        // 6. stream 10 nibbles with interleaved reads across the wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b1, 4'(i + 6), (i % 3) != 0);
        end
        while (q.size() > 0) cycle(1'b1, 1'b0, 4'h0, 1'b1);
        chk("lit_stream_last", 32'(dout), 32'hF);

        // mid-stream reset with three entries held
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 4'(i + 2), 1'b0);
        chk("lit_pre_rst_count", 32'(count), 32'd3);
        cycle(1'b0, 1'b0, 4'h0, 1'b0);
        chk("lit_mid_rst_count", 32'(count),     32'd0);
        chk("lit_mid_rst_unf",   32'(underflow), 32'd0);
        cycle(1'b1, 1'b1, 4'hE, 1'b0);
        cycle(1'b1, 1'b0, 4'h0, 1'b1);
        chk("lit_mid_rst_read", 32'(dout), 32'hE);

        // randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 60) != 0),
                  ($urandom_range(0, 99) < 55),
                  4'($urandom),
                  ($urandom_range(0, 99) < 45));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
